// File: rtl/mux_f_tree_cfg_if.sv
// Bundle of the datapath and serial-configuration signals of one mux_f_tree_cfg slice.
// Pure wiring: no storage, no latency.
// No backpressure: configuration is paced by cen/cfg_commit from the master side.
interface mux_f_tree_cfg_if #(
    parameter int NUM_LUTS  = 8,
    parameter int MUX_LEVEL = 3
);
    logic [NUM_LUTS-1:0]  luts_out;
    logic [MUX_LEVEL-1:0] addr;
    logic [NUM_LUTS-1:0]  out;
    logic                 cen;
    logic                 config_in;
    logic                 config_out;
    logic                 cfg_commit;
    logic                 cfg_loaded;
    logic                 cfg_err;

    // Configuration controller / LUT array side
    modport master (
        output luts_out, addr, cen, config_in, cfg_commit,
        input  out, config_out, cfg_loaded, cfg_err
    );

    // Mux tree slice side
    modport slave (
        input  luts_out, addr, cen, config_in, cfg_commit,
        output out, config_out, cfg_loaded, cfg_err
    );
endinterface

// File: rtl/mux_f_tree_cfg.sv
// CLB output mux tree, one enable bit per node, serial shadow config with atomic commit.
// Latency: out is combinational from luts_out/addr/active (1 cycle when MUX_F_TREE_OUT_REG_EN is defined).
// No backpressure: shifts on cen, commits on cfg_commit; incomplete commits are dropped and flag cfg_err.
module mux_f_tree_cfg #(
    parameter int NUM_LUTS  = 8,
    parameter int MUX_LEVEL = 3
) (
    input  logic               cclk,
    input  logic               rst_n,
    mux_f_tree_cfg_if.slave    bus
);

    localparam int CFG_BITS = NUM_LUTS - 1;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    // The tree shape is fixed by NUM_LUTS; a mismatched depth would silently drop LUTs.
    if (NUM_LUTS < 2 || (NUM_LUTS & (NUM_LUTS - 1)) != 0 || MUX_LEVEL != $clog2(NUM_LUTS)) begin : g_bad_param
        $error("mux_f_tree_cfg: NUM_LUTS must be a power of two >= 2 and MUX_LEVEL == log2(NUM_LUTS)");
    end

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [CFG_BITS-1:0] w_shadow_nxt;
    logic                w_loaded;
    logic [NUM_LUTS-1:0] w_tree;

    assign w_loaded = (r_cnt == CNT_W'(CFG_BITS));

    // A single-node tree has no lower bits to shift along.
    if (CFG_BITS == 1) begin : g_shift_one
        assign w_shadow_nxt = bus.config_in;
    end else begin : g_shift_many
        assign w_shadow_nxt = {r_shadow[CFG_BITS-2:0], bus.config_in};
    end

    // Shadow shift chain, atomic commit to active, saturating load counter and sticky error.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            // Commit samples the pre-edge shadow, so a same-cycle shift never leaks in.
            if (bus.cfg_commit) begin
                if (w_loaded) begin
                    r_active <= r_shadow;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (bus.cen) begin
                r_shadow <= w_shadow_nxt;
            end
            // A valid commit restarts the count; a coincident shift counts as the first new bit.
            if (bus.cfg_commit && w_loaded) begin
                r_cnt <= bus.cen ? CNT_W'(1) : '0;
            end else if (bus.cen && !w_loaded) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Tree levels: each level-k node sits on the group base index; all other bits pass through.
    for (genvar k = 1; k <= MUX_LEVEL; k++) begin : g_lvl
        localparam int OFF  = NUM_LUTS - (NUM_LUTS >> (k - 1));
        localparam int SPAN = 1 << k;
        localparam int HALF = 1 << (k - 1);
        logic [NUM_LUTS-1:0] w_prev;
        logic [NUM_LUTS-1:0] w_val;

        if (k == 1) begin : g_first
            assign w_prev = bus.luts_out;
        end else begin : g_next
            assign w_prev = g_lvl[k-1].w_val;
        end

        for (genvar i = 0; i < NUM_LUTS; i++) begin : g_bit
            if (i % SPAN == 0) begin : g_node
                assign w_val[i] = (r_active[OFF + i / SPAN] && bus.addr[k-1]) ? w_prev[i + HALF] : w_prev[i];
            end else begin : g_pass
                assign w_val[i] = w_prev[i];
            end
        end
    end

    assign w_tree = g_lvl[MUX_LEVEL].w_val;

`ifdef MUX_F_TREE_OUT_REG_EN
    logic [NUM_LUTS-1:0] r_out;

    // Output register for timing closure into the CLB output stage.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_tree;
        end
    end

    assign bus.out = r_out;
`else
    assign bus.out = w_tree;
`endif

    assign bus.config_out = r_shadow[CFG_BITS-1];
    assign bus.cfg_loaded = w_loaded;
    assign bus.cfg_err    = r_err;

endmodule

// File: tb/tb_mux_f_tree_cfg.sv
// Directed bench for mux_f_tree_cfg (NUM_LUTS=8): table of configured datapath vectors
// plus hand sequences for reset, early commit, chaining, reset mid-load and commit+shift.
// Works with and without MUX_F_TREE_OUT_REG_EN defined.
module tb_mux_f_tree_cfg;

    logic cclk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mux_f_tree_cfg_if #(.NUM_LUTS(8), .MUX_LEVEL(3)) bus ();

    mux_f_tree_cfg #(.NUM_LUTS(8), .MUX_LEVEL(3)) dut (
        .cclk  (cclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    typedef struct {
        logic [6:0] cfg;
        logic [7:0] luts;
        logic [2:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [11];
    logic [6:0] cur_cfg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled before the next one.
    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    // Combinational out needs only a delta; registered out needs one more edge.
    task automatic settle();
`ifdef MUX_F_TREE_OUT_REG_EN
        step();
`else
        #1;
`endif
    endtask

    task automatic shift_bit(input logic b);
        bus.cen       = 1'b1;
        bus.config_in = b;
        step();
        bus.cen       = 1'b0;
        bus.config_in = 1'b0;
    endtask

    task automatic commit();
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
    endtask

    task automatic load_cfg(input logic [6:0] c);
        for (int i = 6; i >= 0; i--) shift_bit(c[i]);
    endtask

    task automatic drive(input logic [7:0] l, input logic [2:0] a);
        bus.luts_out = l;
        bus.addr     = a;
        settle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // cfg bits: [3:0] level-1 nodes (bases 0,2,4,6), [5:4] level-2 (bases 0,4), [6] top
        vecs[0]  = '{7'h7F, 8'h80, 3'b111, 8'hD1};
        vecs[1]  = '{7'h7F, 8'h80, 3'b000, 8'h80};
        vecs[2]  = '{7'h7F, 8'hA5, 3'b001, 8'hF0};
        vecs[3]  = '{7'h0F, 8'h02, 3'b001, 8'h03};
        vecs[4]  = '{7'h0F, 8'h02, 3'b101, 8'h03};
        vecs[5]  = '{7'h0F, 8'h10, 3'b111, 8'h00};
        vecs[6]  = '{7'h40, 8'h10, 3'b100, 8'h11};
        vecs[7]  = '{7'h40, 8'h10, 3'b011, 8'h10};
        vecs[8]  = '{7'h00, 8'h5A, 3'b111, 8'h5A};
        vecs[9]  = '{7'h30, 8'h44, 3'b010, 8'h55};
        vecs[10] = '{7'h01, 8'hFE, 3'b001, 8'hFF};

        // Reset held for two cycles while shifting ones in
        rst_n          = 1'b0;
        bus.cen        = 1'b1;
        bus.config_in  = 1'b1;
        bus.cfg_commit = 1'b0;
        bus.luts_out   = 8'hA5;
        bus.addr       = 3'b000;
        step();
        step();
        check("rst_cfg_loaded", 32'(bus.cfg_loaded), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_config_out", 32'(bus.config_out), 32'd0);
`ifdef MUX_F_TREE_OUT_REG_EN
        check("rst_out_reg_zero", 32'(bus.out), 32'd0);
`endif
        bus.cen       = 1'b0;
        bus.config_in = 1'b0;
        rst_n         = 1'b1;
        drive(8'hA5, 3'b111);
        check("rst_out_passthru", 32'(bus.out), 32'hA5);

        // Early commit after only 4 bits is ignored and flags the sticky error
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        check("early_not_loaded", 32'(bus.cfg_loaded), 32'd0);
        commit();
        check("early_cfg_err", 32'(bus.cfg_err), 32'd1);
        drive(8'h80, 3'b111);
        check("early_out_passthru", 32'(bus.out), 32'h80);

        // Full load of all-ones, then a valid commit
        load_cfg(7'h7F);
        check("full_loaded_before", 32'(bus.cfg_loaded), 32'd1);
        drive(8'h80, 3'b111);
        check("shadow_not_visible", 32'(bus.out), 32'h80);
        commit();
        check("full_loaded_after", 32'(bus.cfg_loaded), 32'd0);
        check("err_sticky_after_commit", 32'(bus.cfg_err), 32'd1);
        cur_cfg = 7'h7F;

        // Table-driven datapath vectors, reloading the configuration when it changes
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].cfg != cur_cfg) begin
                load_cfg(vecs[v].cfg);
                commit();
                cur_cfg = vecs[v].cfg;
            end
            drive(vecs[v].luts, vecs[v].addr);
            check($sformatf("vec%0d_out", v), 32'(bus.out), 32'(vecs[v].exp));
        end
        check("err_still_set", 32'(bus.cfg_err), 32'd1);

        // Chaining: config_out presents the shadow MSB, counter saturates
        load_cfg(7'b1010101);
        check("chain_loaded", 32'(bus.cfg_loaded), 32'd1);
        check("chain_out0", 32'(bus.config_out), 32'd1);
        shift_bit(1'b0);
        check("chain_out1", 32'(bus.config_out), 32'd0);
        shift_bit(1'b0);
        check("chain_out2", 32'(bus.config_out), 32'd1);
        shift_bit(1'b0);
        check("chain_saturated", 32'(bus.cfg_loaded), 32'd1);

        // Reset in the middle of a load clears shadow, active, counter and error
        load_cfg(7'h00);
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_loaded", 32'(bus.cfg_loaded), 32'd0);
        check("midrst_config_out", 32'(bus.config_out), 32'd0);
        check("midrst_err_clear", 32'(bus.cfg_err), 32'd0);
        drive(8'hA5, 3'b111);
        check("midrst_out_passthru", 32'(bus.out), 32'hA5);

        // Reload 0F; after 6 bits a stale shadow would put a 1 on config_out
        for (int i = 6; i >= 1; i--) shift_bit(i <= 3);
        check("reload_partial", 32'(bus.cfg_loaded), 32'd0);
        check("reload_shadow_clean", 32'(bus.config_out), 32'd0);
        shift_bit(1'b1);
        check("reload_full", 32'(bus.cfg_loaded), 32'd1);

        // Shift and commit together: pre-shift shadow (0F) is committed, counter lands on 1
        bus.cen        = 1'b1;
        bus.config_in  = 1'b0;
        bus.cfg_commit = 1'b1;
        step();
        bus.cen        = 1'b0;
        bus.cfg_commit = 1'b0;
        check("simul_loaded_low", 32'(bus.cfg_loaded), 32'd0);
        check("simul_no_err", 32'(bus.cfg_err), 32'd0);
        drive(8'h02, 3'b001);
        check("simul_committed_pre_shift", 32'(bus.out), 32'h03);
        for (int i = 0; i < 5; i++) shift_bit(1'b0);
        check("simul_cnt_six", 32'(bus.cfg_loaded), 32'd0);
        shift_bit(1'b0);
        check("simul_cnt_seven", 32'(bus.cfg_loaded), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
